// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
//   Instruction-fetch front end. Owns the program counter, drives the read
//   address of the instruction RAM's synchronous port A and pairs each
//   returned word with its PC for decode. Absorbs the one-cycle BRAM read
//   latency, decode stalls, control-flow redirects and misaligned-target
//   faults.
//
// Optional feature macro: IF_PERF_CNT_EN
//   defined   -> fetch_cnt_o / stall_cnt_o are live 32-bit wrapping counters
//   undefined -> both ports tied to zero, no counter registers
//
// Parameters
//   RESET_PC          first fetch address after reset (bits [1:0] zero)
// Ports
//   clk               pipeline clock, rising edge
//   rst               asynchronous active-high reset
//   stall_i           decode cannot accept this cycle's instruction
//   redirect_valid_i  taken branch/jump, refetch from redirect_pc_i
//   redirect_pc_i     redirect target byte address
//   inst_addr_o       port A read address (combinational)
//   inst_rdata_i      port A read data, one cycle after its address
//   inst_o            instruction to decode (= inst_rdata_i)
//   pc_o              byte address of inst_o
//   valid_o           inst_o/pc_o carry a live instruction
//   fault_o           sticky misaligned-redirect fault
//   fault_pc_o        offending redirect target
//   fetch_cnt_o       delivered instructions
//   stall_cnt_o       stall cycles seen in RUN
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] inst_addr_o,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        fault_o,
  output logic [31:0] fault_pc_o,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
);

  localparam logic [1:0] PRIME = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] issue_pc;
  logic        redir_ok;
  logic        redir_bad;
  logic        in_run;

  assign in_run    = (state == RUN);
  assign redir_bad = redirect_valid_i & (redirect_pc_i[1:0] != 2'b00);
  assign redir_ok  = redirect_valid_i & ~redir_bad;

  // Address select. Outside RUN the BRAM keeps re-reading issue_pc; on a
  // stall the same word is re-read so inst_rdata_i stays constant.
  always_comb begin
    inst_addr_o = issue_pc;
    if (in_run) begin
      if (redir_ok)
        inst_addr_o = redirect_pc_i;
      else if (stall_i)
        inst_addr_o = issue_pc;
      else
        inst_addr_o = issue_pc + 32'd4;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PRIME:   state_nxt = RUN;
      RUN:     state_nxt = redir_bad ? FAULT : RUN;
      FAULT:   state_nxt = FAULT;
      default: state_nxt = PRIME;
    endcase
  end

  // The word on inst_rdata_i belongs to issue_pc; a redirect squashes it.
  assign valid_o = in_run & ~redirect_valid_i;
  assign pc_o    = issue_pc;
  assign inst_o  = inst_rdata_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PRIME;
      issue_pc   <= RESET_PC;
      fault_o    <= 1'b0;
      fault_pc_o <= 32'h0;
    end else begin
      state <= state_nxt;
      if (in_run)
        issue_pc <= inst_addr_o;
      if (in_run && redir_bad) begin
        fault_o    <= 1'b1;
        fault_pc_o <= redirect_pc_i;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if (valid_o && !stall_i)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (in_run && stall_i)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt;
  assign stall_cnt_o = stall_cnt;
`else
  assign fetch_cnt_o = 32'h0;
  assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        rv;
  logic [31:0] rpc;
  logic [31:0] inst_addr;
  logic [31:0] rdata;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        valid;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  inst_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_valid_i(rv),
    .redirect_pc_i(rpc), .inst_addr_o(inst_addr), .inst_rdata_i(rdata),
    .inst_o(inst), .pc_o(pc), .valid_o(valid), .fault_o(fault),
    .fault_pc_o(fault_pc), .fetch_cnt_o(fetch_cnt), .stall_cnt_o(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1 KiB instruction RAM; addresses with upper bits set read as zero.
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    if (a[31:10] != 22'h0) return 32'h0;
    return 32'hC0DE_0000 | {24'h0, a[9:2]};
  endfunction

  always_ff @(posedge clk) rdata <= ram_word(inst_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic s, input logic r, input logic [31:0] t,
                              input logic ev, input logic [31:0] epc);
    vec_t v;
    v.stall = s; v.rv = r; v.rpc = t; v.ev = ev; v.epc = epc;
    vecs.push_back(v);
  endfunction

  int exp_fetch;
  int exp_stall;

  initial begin
    rst = 1'b1; stall = 1'b0; rv = 1'b0; rpc = 32'h0;

    // Row 0 is the PRIME cycle right after reset release.
    add(0, 0, 32'h0,         0, 32'h0);
    add(0, 0, 32'h0,         1, 32'h0);
    add(0, 0, 32'h0,         1, 32'h4);
    add(1, 0, 32'h0,         1, 32'h8);
    add(1, 0, 32'h0,         1, 32'h8);
    add(1, 0, 32'h0,         1, 32'h8);
    add(0, 0, 32'h0,         1, 32'h8);
    add(0, 0, 32'h0,         1, 32'hC);
    add(0, 1, 32'h40,        0, 32'h10);
    add(0, 0, 32'h0,         1, 32'h40);
    add(1, 1, 32'h20,        0, 32'h44);
    add(0, 0, 32'h0,         1, 32'h20);
    add(0, 0, 32'h0,         1, 32'h24);
    add(0, 1, 32'h8000_0000, 0, 32'h28);
    add(0, 0, 32'h0,         1, 32'h8000_0000);
    add(0, 0, 32'h0,         1, 32'h8000_0004);
    add(0, 1, 32'hFFFF_FFFC, 0, 32'h8000_0008);
    add(0, 0, 32'h0,         1, 32'hFFFF_FFFC);
    add(0, 0, 32'h0,         1, 32'h0);
    add(0, 1, 32'h22,        0, 32'h4);

    // Reset state
    #12;
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_fault_pc", fault_pc, 32'h0);
    chk("rst_addr", inst_addr, 32'h0);
    chk("rst_fetch_cnt", fetch_cnt, 32'h0);
    chk("rst_stall_cnt", stall_cnt, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    exp_fetch = 0;
    exp_stall = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      stall = vecs[i].stall; rv = vecs[i].rv; rpc = vecs[i].rpc;
      #1;
      chk($sformatf("valid[%0d]", i), {31'h0, valid}, {31'h0, vecs[i].ev});
      chk($sformatf("fault[%0d]", i), {31'h0, fault}, 32'h0);
      if (vecs[i].ev) begin
        chk($sformatf("pc[%0d]", i), pc, vecs[i].epc);
        chk($sformatf("inst[%0d]", i), inst, ram_word(vecs[i].epc));
      end
      if (i >= 1 && vecs[i].stall) exp_stall++;
      if (vecs[i].ev && !vecs[i].stall) exp_fetch++;
    end

    // Sticky fault: outputs stay dead and counters hold whatever the inputs do.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      stall = (k != 1); rv = (k == 2); rpc = 32'h100;
      #1;
      chk($sformatf("flt_fault[%0d]", k), {31'h0, fault}, 32'h1);
      chk($sformatf("flt_pc[%0d]", k), fault_pc, 32'h22);
      chk($sformatf("flt_valid[%0d]", k), {31'h0, valid}, 32'h0);
`ifdef IF_PERF_CNT_EN
      chk($sformatf("flt_fetch_cnt[%0d]", k), fetch_cnt, exp_fetch);
      chk($sformatf("flt_stall_cnt[%0d]", k), stall_cnt, exp_stall);
`else
      chk($sformatf("flt_fetch_cnt[%0d]", k), fetch_cnt, 32'h0);
      chk($sformatf("flt_stall_cnt[%0d]", k), stall_cnt, 32'h0);
`endif
    end

    // Asynchronous reset mid-cycle clears everything at once.
    stall = 1'b0; rv = 1'b0; rpc = 32'h0;
    #2 rst = 1'b1;
    #1;
    chk("arst_fault", {31'h0, fault}, 32'h0);
    chk("arst_fault_pc", fault_pc, 32'h0);
    chk("arst_valid", {31'h0, valid}, 32'h0);
    chk("arst_addr", inst_addr, 32'h0);
    chk("arst_fetch_cnt", fetch_cnt, 32'h0);
    chk("arst_stall_cnt", stall_cnt, 32'h0);

    // Restart: PRIME bubble, then word 0, word 1.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("re_prime_valid", {31'h0, valid}, 32'h0);
    @(negedge clk); #1;
    chk("re_valid0", {31'h0, valid}, 32'h1);
    chk("re_pc0", pc, 32'h0);
    chk("re_inst0", inst, ram_word(32'h0));
    @(negedge clk); #1;
    chk("re_pc1", pc, 32'h4);
    chk("re_inst1", inst, ram_word(32'h4));
`ifdef IF_PERF_CNT_EN
    chk("re_fetch_cnt", fetch_cnt, 32'h1);
`else
    chk("re_fetch_cnt", fetch_cnt, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
